load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
//  Multi-cycle RV32I load/store unit between the CPU core and the data-memory port.
//  Replaces fixed one-cycle load stalls with a req/resp handshake and parametrised
//  memory latency. Performs byte-lane alignment for SB/SH/SW and sign/zero extension
//  for LB/LH/LW/LBU/LHU. Flags misaligned or illegal accesses without touching memory.
// PARAMETERS
//  RD_LATENCY  1  cycles data_read is held before data_out is sampled (legal 1..15)
//  WR_LATENCY  1  cycles data_write mask is held for a store (legal 1..15)
// PORTS
//  clk            in   1   clock; all state updates on posedge
//  rst            in   1   synchronous, active-high reset
//  req_valid      in   1   core presents a memory operation
//  req_ready      out  1   LSU can accept (high only in IDLE)
//  req_we         in   1   1 = store, 0 = load
//  req_funct3     in   3   RV32I funct3 of the load/store
//  req_addr       in   32  effective byte address (ALU result)
//  req_wdata      in   32  store data (rs2), unaligned, in low bits
//  resp_valid     out  1   one-cycle pulse: operation complete
//  resp_rdata     out  32  extended load result (0 for stores and errors)
//  resp_err       out  1   misaligned or illegal funct3; valid with resp_valid
//  data_read      out  1   memory read strobe
//  data_write     out  4   byte write enables, bit i -> data_in[8i+7:8i]
//  data_addr      out  32  word-aligned address {req_addr[31:2],2'b00}
//  data_in        out  32  lane-aligned store data, unused lanes 0
//  data_out       in   32  memory read data, little-endian lanes
// BEHAVIOUR
//  - Reset: state=IDLE; req_ready=1; resp_valid=0, resp_rdata=0, resp_err=0;
//    data_read=0, data_write=0, data_addr=0, data_in=0. Reset mid-operation aborts
//    it: strobes low from the first cycle after the reset edge, no resp_valid.
//  - Accept when req_valid & req_ready at a posedge; addr/funct3/we/wdata latched.
//  - States: IDLE, RD_WAIT, WR_WAIT, RESP.
//    IDLE -> RD_WAIT (load, legal) | WR_WAIT (store, legal) | RESP (error).
//    RD_WAIT: data_read=1, data_addr held; cnt counts 0..RD_LATENCY-1; on last
//      cycle data_out captured and extended into resp_rdata; -> RESP.
//    WR_WAIT: data_write=mask, data_in=aligned data for WR_LATENCY cycles; -> RESP.
//    RESP: resp_valid=1 for exactly one cycle; -> IDLE. req_ready=0 here.
//  - Load latency: resp_valid RD_LATENCY+1 cycles after acceptance edge; store:
//    WR_LATENCY+1. Error: resp_valid 1 cycle after acceptance, no strobes.
//  - Memory strobes are 0 in IDLE and RESP; data_read and data_write never both set.
//  - Alignment (off=addr[1:0]): byte any off; half needs off[0]=0; word needs off=0.
//  - Store masks: SB 4'b0001<<off; SH 4'b0011<<off; SW 4'b1111; data_in = wdata<<8*off.
//  - Loads: lane = data_out>>8*off; LB/LH sign-extend bit7/bit15; LBU/LHU zero-extend.
//  - Illegal funct3: loads 011,110,111; stores >=011 -> resp_err=1, resp_rdata=0.
//  - resp_rdata/resp_err hold their value until the next RESP; only resp_valid pulses.
//  - req_valid while req_ready=0 is ignored (core must hold it); no queuing.
//  - cnt width $clog2(max(RD_LATENCY,WR_LATENCY)+1); cnt cleared on every IDLE exit.
// STRUCTURE
//  - Shared package cpu_pkg: funct3 constants F3_B/H/W/BU/HU, lsu_state_t encoding,
//    LSU_MAX_LAT=15.
//  - Sub-module lsu_lane_align (combinational): funct3, off, wdata, data_out ->
//    mask, data_in, extended rdata, misaligned/illegal flag. FSM + counter stay here.
// TESTING
//  - LW addr 0x100, data_out 0xDEADBEEF, RD_LATENCY=3 -> data_read high 3 cycles,
//    resp_valid on 4th cycle after accept, resp_rdata=0xDEADBEEF, resp_err=0.
//  - LB addr 0x103, data_out 0x80FF0000 -> data_addr 0x100, resp_rdata 0xFFFFFF80;
//    LBU same -> 0x00000080; LH addr 0x102 -> 0xFFFF80FF.
//  - SH addr 0x206 wdata 0x1234ABCD -> data_write 4'b1100, data_in 0xABCD0000,
//    data_addr 0x204, held WR_LATENCY cycles, then resp_valid.
//  - SW addr 0x301 -> no strobes ever, resp_valid next cycle with resp_err=1;
//    load funct3 3'b011 -> same.
//  - Assert rst during RD_WAIT cycle 2 -> next cycle data_read=0, req_ready=1,
//    no resp_valid; then back-to-back SB/LW complete with correct results.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the load/store unit: funct3 codes, LSU state encoding
// and the upper bound on memory latency.
package cpu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int unsigned LSU_MAX_LAT = 15;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StRdWait = 2'b01,
    StWrWait = 2'b10,
    StResp   = 2'b11
  } lsu_state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: store masks and shifted write data, load lane
// extraction with sign/zero extension, and misaligned/illegal-funct3 detection.
module lsu_lane_align
  import cpu_pkg::*;
(
  input  logic        i_we,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_data_out,
  output logic [3:0]  o_mask,
  output logic [31:0] o_data_in,
  output logic [31:0] o_rdata,
  output logic        o_err
);

  logic [31:0] w_lane;
  logic [31:0] w_wsized;

  always_comb begin
    w_lane   = i_data_out >> {i_off, 3'b000};
    o_err    = 1'b1;
    o_mask   = 4'b0000;
    w_wsized = 32'h0;
    o_rdata  = 32'h0;
    if (i_we) begin
      case (i_funct3)
        F3_B: begin
          o_err    = 1'b0;
          o_mask   = 4'b0001 << i_off;
          w_wsized = {24'h0, i_wdata[7:0]};
        end
        F3_H: begin
          o_err    = i_off[0];
          o_mask   = 4'b0011 << i_off;
          w_wsized = {16'h0, i_wdata[15:0]};
        end
        F3_W: begin
          o_err    = (i_off != 2'b00);
          o_mask   = 4'b1111;
          w_wsized = i_wdata;
        end
        default: ;
      endcase
    end else begin
      case (i_funct3)
        F3_B: begin
          o_err   = 1'b0;
          o_rdata = {{24{w_lane[7]}}, w_lane[7:0]};
        end
        F3_BU: begin
          o_err   = 1'b0;
          o_rdata = {24'h0, w_lane[7:0]};
        end
        F3_H: begin
          o_err   = i_off[0];
          o_rdata = {{16{w_lane[15]}}, w_lane[15:0]};
        end
        F3_HU: begin
          o_err   = i_off[0];
          o_rdata = {16'h0, w_lane[15:0]};
        end
        F3_W: begin
          o_err   = (i_off != 2'b00);
          o_rdata = w_lane;
        end
        default: ;
      endcase
    end
    // Faulting accesses must never drive lanes or return data.
    if (o_err) begin
      o_mask   = 4'b0000;
      o_rdata  = 32'h0;
      w_wsized = 32'h0;
    end
    o_data_in = w_wsized << {i_off, 3'b000};
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle RV32I load/store unit: accepts one request in idle, holds memory strobes
// for a parametrised latency, then pulses a one-cycle response.
module load_store_unit
  import cpu_pkg::*;
#(
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned WR_LATENCY = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [2:0]  i_req_funct3,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_resp_valid,
  output logic [31:0] o_resp_rdata,
  output logic        o_resp_err,
  output logic        o_data_read,
  output logic [3:0]  o_data_write,
  output logic [31:0] o_data_addr,
  output logic [31:0] o_data_in,
  input  logic [31:0] i_data_out
);

  localparam int unsigned MaxLat = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
  localparam int unsigned CntW   = $clog2(MaxLat + 1);

  lsu_state_t      r_state;
  logic [CntW-1:0] r_cnt;
  logic [2:0]      r_funct3;
  logic [1:0]      r_off;
  logic            r_we;

  logic        w_accept;
  logic        w_sel_we;
  logic [2:0]  w_sel_funct3;
  logic [1:0]  w_sel_off;
  logic [3:0]  w_mask;
  logic [31:0] w_data_in;
  logic [31:0] w_rdata;
  logic        w_err;

  assign w_accept = i_req_valid & o_req_ready;

  // In idle the aligner classifies the incoming request; afterwards it sees the latched one.
  assign w_sel_we     = (r_state == StIdle) ? i_req_we        : r_we;
  assign w_sel_funct3 = (r_state == StIdle) ? i_req_funct3    : r_funct3;
  assign w_sel_off    = (r_state == StIdle) ? i_req_addr[1:0] : r_off;

  lsu_lane_align u_align (
    .i_we       (w_sel_we),
    .i_funct3   (w_sel_funct3),
    .i_off      (w_sel_off),
    .i_wdata    (i_req_wdata),
    .i_data_out (i_data_out),
    .o_mask     (w_mask),
    .o_data_in  (w_data_in),
    .o_rdata    (w_rdata),
    .o_err      (w_err)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= StIdle;
      r_cnt        <= '0;
      r_funct3     <= 3'b000;
      r_off        <= 2'b00;
      r_we         <= 1'b0;
      o_req_ready  <= 1'b1;
      o_resp_valid <= 1'b0;
      o_resp_rdata <= 32'h0;
      o_resp_err   <= 1'b0;
      o_data_read  <= 1'b0;
      o_data_write <= 4'b0000;
      o_data_addr  <= 32'h0;
      o_data_in    <= 32'h0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_funct3    <= i_req_funct3;
            r_off       <= i_req_addr[1:0];
            r_we        <= i_req_we;
            r_cnt       <= '0;
            o_req_ready <= 1'b0;
            if (w_err) begin
              r_state      <= StResp;
              o_resp_valid <= 1'b1;
              o_resp_err   <= 1'b1;
              o_resp_rdata <= 32'h0;
            end else if (i_req_we) begin
              r_state      <= StWrWait;
              o_data_write <= w_mask;
              o_data_in    <= w_data_in;
              o_data_addr  <= {i_req_addr[31:2], 2'b00};
            end else begin
              r_state     <= StRdWait;
              o_data_read <= 1'b1;
              o_data_addr <= {i_req_addr[31:2], 2'b00};
            end
          end
        end
        StRdWait: begin
          if (r_cnt == CntW'(RD_LATENCY - 1)) begin
            r_state      <= StResp;
            o_data_read  <= 1'b0;
            o_resp_valid <= 1'b1;
            o_resp_rdata <= w_rdata;
            o_resp_err   <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StWrWait: begin
          if (r_cnt == CntW'(WR_LATENCY - 1)) begin
            r_state      <= StResp;
            o_data_write <= 4'b0000;
            o_data_in    <= 32'h0;
            o_resp_valid <= 1'b1;
            o_resp_rdata <= 32'h0;
            o_resp_err   <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StResp: begin
          r_state      <= StIdle;
          o_resp_valid <= 1'b0;
          o_req_ready  <= 1'b1;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule
